// File: rtl/mc_main_ctrl.sv
// Moore control FSM for the multicycle MIPS core: sequences fetch/decode/execute
// and drives datapath selects, with optional memory wait states and illegal-op trapping.
module mc_main_ctrl #(
  parameter bit MEM_WAIT     = 1'b0,
  parameter bit EN_LWSW      = 1'b1,
  parameter bit EN_BNE       = 1'b1,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       branch_ne,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] pc_src,
  output logic       imm_zext,
  output logic       illegal,
  output logic       retire,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEX   = 4'd6,  S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,  S_ADDIEX = 4'd9,  S_IMMWB  = 4'd10, S_JUMP   = 4'd11,
    S_ORIEX  = 4'd12, S_ANDIEX = 4'd13, S_BNE    = 4'd14, S_ILLEGAL = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW   = 6'h23, OP_SW    = 6'h2B,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI  = 6'h08,
                         OP_ADDIU = 6'h09, OP_ANDI = 6'h0C, OP_ORI   = 6'h0D,
                         OP_J     = 6'h02;

  localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000,
                         ALU_OR  = 3'b001, ALU_SLT = 3'b111;

  state_t     state_q, state_d, dec_state;
  logic       rdy, r_ok;
  logic [2:0] r_alu;

  assign rdy   = MEM_WAIT ? mem_ready : 1'b1;
  assign state = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    r_ok  = 1'b1;
    r_alu = ALU_ADD;
    case (funct)
      6'h20:   r_alu = ALU_ADD;
      6'h22:   r_alu = ALU_SUB;
      6'h24:   r_alu = ALU_AND;
      6'h25:   r_alu = ALU_OR;
      6'h2A:   r_alu = ALU_SLT;
      default: r_ok  = 1'b0;
    endcase
  end

  // Anything not matched below falls through to the illegal-instruction path.
  always_comb begin
    if (TRAP_ILLEGAL) dec_state = S_ILLEGAL;
    else              dec_state = S_FETCH;
    case (opcode)
      OP_RTYPE:          if (r_ok)    dec_state = S_RTEX;
      OP_LW, OP_SW:      if (EN_LWSW) dec_state = S_MEMADR;
      OP_BEQ:                         dec_state = S_BEQ;
      OP_BNE:            if (EN_BNE)  dec_state = S_BNE;
      OP_ADDI, OP_ADDIU:              dec_state = S_ADDIEX;
      OP_ANDI:                        dec_state = S_ANDIEX;
      OP_ORI:                         dec_state = S_ORIEX;
      OP_J:                           dec_state = S_JUMP;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    branch      = 1'b0;
    branch_ne   = 1'b0;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    pc_src      = 2'b00;
    imm_zext    = 1'b0;
    illegal     = 1'b0;
    retire      = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        ir_write    = rdy;
        pc_write    = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
        // Non-trapping illegal opcodes retire here as a NOP.
        retire      = (dec_state == S_FETCH);
        state_d     = dec_state;
      end
      S_MEMADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_d     = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        retire    = rdy;
        if (rdy) state_d = S_FETCH;
      end
      S_RTEX: begin
        alu_src_a   = 1'b1;
        alu_control = r_alu;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX, S_ANDIEX, S_ORIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = (state_q == S_ANDIEX) ? ALU_AND :
                      (state_q == S_ORIEX)  ? ALU_OR  : ALU_ADD;
        imm_zext    = (state_q != S_ADDIEX);
        state_d     = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ, S_BNE: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        branch      = (state_q == S_BEQ);
        branch_ne   = (state_q == S_BNE);
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_ILLEGAL: illegal = 1'b1;
      default:   state_d = S_FETCH;
    endcase
    // Reset silences every strobe in the same cycle so an abandoned access never writes.
    if (rst) begin
      pc_write    = 1'b0;
      branch      = 1'b0;
      branch_ne   = 1'b0;
      iord        = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_control = 3'b000;
      pc_src      = 2'b00;
      imm_zext    = 1'b0;
      illegal     = 1'b0;
      retire      = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Bench for mc_main_ctrl: three configurations, a vector table, hand sequences for
// waits/reset/traps, and random instruction streams against an instruction-level model.
module tb_mc_main_ctrl;

  // Instance 0: MEM_WAIT=1, all enabled, trapping.
  // Instance 1: no waits, BNE disabled, trapping.
  // Instance 2: no waits, LW/SW disabled, non-trapping.
  localparam logic [2:0] MW = 3'b001;
  localparam logic [2:0] LS = 3'b011;
  localparam logic [2:0] BN = 3'b101;
  localparam logic [2:0] TR = 3'b011;

  logic        clk = 1'b0;
  logic [2:0]  rst_v, rdy_v;
  logic [5:0]  op_v [3];
  logic [5:0]  fn_v [3];
  logic [23:0] obs  [3];
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       pw, br, bne, iord, mw, irw, rd, m2r, rw, asa, imz, ill, ret;
    logic [1:0] asb, pcs;
    logic [2:0] alc;
    logic [3:0] st;
    mc_main_ctrl #(.MEM_WAIT(MW[g]), .EN_LWSW(LS[g]), .EN_BNE(BN[g]), .TRAP_ILLEGAL(TR[g])) dut (
      .clk(clk), .rst(rst_v[g]), .opcode(op_v[g]), .funct(fn_v[g]), .mem_ready(rdy_v[g]),
      .pc_write(pw), .branch(br), .branch_ne(bne), .iord(iord), .mem_write(mw),
      .ir_write(irw), .reg_dst(rd), .mem_to_reg(m2r), .reg_write(rw), .alu_src_a(asa),
      .alu_src_b(asb), .alu_control(alc), .pc_src(pcs), .imm_zext(imz), .illegal(ill),
      .retire(ret), .state(st));
    assign obs[g] = {pw, br, bne, iord, mw, irw, rd, m2r, rw, asa, asb, alc, pcs, imz, ill, ret, st};
  end

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Instruction -> sequence of states it visits (before any wait repetition).
  function automatic int plan(input int d, input logic [5:0] op, input logic [5:0] fn,
                              output logic [4:0][3:0] s);
    s = '0;
    s[1] = 4'd1;
    if (op == 6'h00 && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A})) begin
      s[2] = 4'd6; s[3] = 4'd7; return 4;
    end
    if (op == 6'h23 && LS[d]) begin s[2] = 4'd2; s[3] = 4'd3; s[4] = 4'd4; return 5; end
    if (op == 6'h2B && LS[d]) begin s[2] = 4'd2; s[3] = 4'd5; return 4; end
    if (op == 6'h04) begin s[2] = 4'd8; return 3; end
    if (op == 6'h05 && BN[d]) begin s[2] = 4'd14; return 3; end
    if (op == 6'h08 || op == 6'h09) begin s[2] = 4'd9;  s[3] = 4'd10; return 4; end
    if (op == 6'h0C) begin s[2] = 4'd13; s[3] = 4'd10; return 4; end
    if (op == 6'h0D) begin s[2] = 4'd12; s[3] = 4'd10; return 4; end
    if (op == 6'h02) begin s[2] = 4'd11; return 3; end
    if (TR[d]) begin s[2] = 4'd15; return 3; end
    return 2;
  endfunction

  // Expected outputs for one cycle spent in a given state.
  function automatic logic [23:0] expv(input logic [3:0] st, input logic [5:0] fn,
                                       input logic re, input logic last);
    logic pw, br, bne, iord, mw, irw, rd, m2r, rw, asa, imz, ill, ret;
    logic [1:0] asb, pcs;
    logic [2:0] alc;
    {pw, br, bne, iord, mw, irw, rd, m2r, rw, asa, imz, ill, ret} = '0;
    asb = 2'b00; pcs = 2'b00; alc = 3'b000;
    case (st)
      4'd0:  begin asb = 2'b01; alc = 3'b010; irw = re; pw = re; end
      4'd1:  begin asb = 2'b11; alc = 3'b010; ret = last; end
      4'd2:  begin asa = 1; asb = 2'b10; alc = 3'b010; end
      4'd3:  iord = 1;
      4'd4:  begin m2r = 1; rw = 1; ret = 1; end
      4'd5:  begin iord = 1; mw = 1; ret = re; end
      4'd6: begin
        asa = 1;
        case (fn)
          6'h22: alc = 3'b110;
          6'h24: alc = 3'b000;
          6'h25: alc = 3'b001;
          6'h2A: alc = 3'b111;
          default: alc = 3'b010;
        endcase
      end
      4'd7:  begin rd = 1; rw = 1; ret = 1; end
      4'd8:  begin asa = 1; alc = 3'b110; pcs = 2'b01; br = 1;  ret = 1; end
      4'd14: begin asa = 1; alc = 3'b110; pcs = 2'b01; bne = 1; ret = 1; end
      4'd9:  begin asa = 1; asb = 2'b10; alc = 3'b010; end
      4'd13: begin asa = 1; asb = 2'b10; alc = 3'b000; imz = 1; end
      4'd12: begin asa = 1; asb = 2'b10; alc = 3'b001; imz = 1; end
      4'd10: begin rw = 1; ret = 1; end
      4'd11: begin pcs = 2'b10; pw = 1; ret = 1; end
      default: ill = 1;
    endcase
    return {pw, br, bne, iord, mw, irw, rd, m2r, rw, asa, asb, alc, pcs, imz, ill, ret, st};
  endfunction

  // Runs one instruction on instance d; fw/mw = mem_ready-low cycles in FETCH / memory state.
  task automatic run(input int d, input logic [5:0] op, input logic [5:0] fn,
                     input int fw, input int mw, output int cyc, output int irw_n);
    logic [4:0][3:0] s;
    int len, k, fl, ml, ill_n;
    logic ri, re;
    len = plan(d, op, fn, s);
    op_v[d] = op; fn_v[d] = fn;
    k = 0; fl = fw; ml = mw; cyc = 0; irw_n = 0; ill_n = 0;
    while (k < len) begin
      ri = 1'b1;
      if (s[k] == 4'd0 && fl > 0) begin ri = 1'b0; fl--; end
      else if ((s[k] == 4'd3 || s[k] == 4'd5) && ml > 0) begin ri = 1'b0; ml--; end
      rdy_v[d] = ri;
      re = MW[d] ? ri : 1'b1;
      @(negedge clk);
      chk($sformatf("d%0d op%h fn%h st%0d", d, op, fn, s[k]), obs[d], expv(s[k], fn, re, k == len - 1));
      if (obs[d][18]) irw_n++;
      @(posedge clk); #1;
      cyc++;
      if (s[k] == 4'd15) begin ill_n++; if (ill_n == 4) k = len; end
      else if (!(s[k] inside {4'd0, 4'd3, 4'd5}) || re) k++;
      if (cyc > 60) begin chk("cycle budget", 24'(cyc), 24'd60); k = len; end
    end
    rdy_v[d] = 1'b1;
  endtask

  task automatic do_reset(input int d);
    rst_v[d] = 1'b1; rdy_v[d] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk($sformatf("reset d%0d", d), obs[d], 24'h0);
    @(posedge clk); #1;
    rst_v[d] = 1'b0;
  endtask

  typedef struct {
    logic [5:0]      op, fn;
    int              len;
    logic [4:0][3:0] st;
    logic [2:0]      alu;
    logic            zx;
  } vec_t;

  function automatic vec_t mkv(input logic [5:0] op, input logic [5:0] fn, input int len,
                               input logic [3:0] s4, input logic [3:0] s3, input logic [3:0] s2,
                               input logic [2:0] alu, input logic zx);
    vec_t v;
    v.op = op; v.fn = fn; v.len = len; v.st = {s4, s3, s2, 4'd1, 4'd0}; v.alu = alu; v.zx = zx;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [15];
    logic [5:0] ops [10];
    logic [5:0] fns [5];
    int cyc, irw_n;
    logic [5:0] op, fn;

    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h02};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    tbl[0]  = mkv(6'h00, 6'h20, 4, 0, 7, 6,  3'b010, 0);
    tbl[1]  = mkv(6'h00, 6'h22, 4, 0, 7, 6,  3'b110, 0);
    tbl[2]  = mkv(6'h00, 6'h24, 4, 0, 7, 6,  3'b000, 0);
    tbl[3]  = mkv(6'h00, 6'h25, 4, 0, 7, 6,  3'b001, 0);
    tbl[4]  = mkv(6'h00, 6'h2A, 4, 0, 7, 6,  3'b111, 0);
    tbl[5]  = mkv(6'h23, 6'h00, 5, 4, 3, 2,  3'b010, 0);
    tbl[6]  = mkv(6'h2B, 6'h00, 4, 0, 5, 2,  3'b010, 0);
    tbl[7]  = mkv(6'h04, 6'h00, 3, 0, 0, 8,  3'b110, 0);
    tbl[8]  = mkv(6'h05, 6'h00, 3, 0, 0, 14, 3'b110, 0);
    tbl[9]  = mkv(6'h08, 6'h00, 4, 0, 10, 9, 3'b010, 0);
    tbl[10] = mkv(6'h09, 6'h00, 4, 0, 10, 9, 3'b010, 0);
    tbl[11] = mkv(6'h0C, 6'h00, 4, 0, 10, 13, 3'b000, 1);
    tbl[12] = mkv(6'h0D, 6'h00, 4, 0, 10, 12, 3'b001, 1);
    tbl[13] = mkv(6'h02, 6'h00, 3, 0, 0, 11, 3'b000, 0);
    tbl[14] = mkv(6'h00, 6'h20, 4, 0, 7, 6,  3'b010, 0);

    rst_v = 3'b111; rdy_v = 3'b111;
    for (int i = 0; i < 3; i++) begin op_v[i] = 6'h00; fn_v[i] = 6'h20; end

    // Instance 0: vector table with mem_ready held high.
    do_reset(0);
    for (int i = 0; i < 15; i++) begin
      op_v[0] = tbl[i].op; fn_v[0] = tbl[i].fn; rdy_v[0] = 1'b1;
      for (int k = 0; k < tbl[i].len; k++) begin
        @(negedge clk);
        chk($sformatf("tbl%0d state k%0d", i, k), 24'(obs[0][3:0]), 24'(tbl[i].st[k]));
        chk($sformatf("tbl%0d retire k%0d", i, k), 24'(obs[0][4]), 24'(k == tbl[i].len - 1));
        if (k == 2) begin
          chk($sformatf("tbl%0d alu", i), 24'(obs[0][11:9]), 24'(tbl[i].alu));
          chk($sformatf("tbl%0d zext", i), 24'(obs[0][6]), 24'(tbl[i].zx));
        end
        @(posedge clk); #1;
      end
    end

    // LW with 2 FETCH waits and 3 MEMRD waits: 10 cycles, one IR load.
    run(0, 6'h23, 6'h00, 2, 3, cyc, irw_n);
    chk("lw wait cycles", 24'(cyc), 24'd10);
    chk("lw ir_write count", 24'(irw_n), 24'd1);
    run(0, 6'h2B, 6'h00, 1, 2, cyc, irw_n);
    chk("sw wait cycles", 24'(cyc), 24'd7);

    // Reset while a store is stalled in MEMWR.
    op_v[0] = 6'h2B; fn_v[0] = 6'h00; rdy_v[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 rdy_v[0] = 1'b0;
    @(negedge clk);
    chk("memwr stall", obs[0], expv(4'd5, 6'h00, 1'b0, 1'b0));
    @(posedge clk); #1;
    rst_v[0] = 1'b1;
    @(negedge clk);
    chk("rst in memwr", obs[0], 24'h000005);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst edge", obs[0], 24'h0);
    @(posedge clk); #1;
    rst_v[0] = 1'b0; rdy_v[0] = 1'b1;
    run(0, 6'h00, 6'h20, 0, 0, cyc, irw_n);
    chk("add after rst", 24'(cyc), 24'd4);

    // Instance 0: random legal stream with random wait states.
    for (int i = 0; i < 150; i++) begin
      op = ops[$urandom_range(0, 9)];
      fn = (op == 6'h00) ? fns[$urandom_range(0, 4)] : 6'($urandom);
      run(0, op, fn, $urandom_range(0, 3), $urandom_range(0, 3), cyc, irw_n);
    end

    // Instance 1: BNE disabled traps; waits ignored.
    do_reset(1);
    run(1, 6'h05, 6'h00, 0, 0, cyc, irw_n);
    op_v[1] = 6'h00;
    @(negedge clk);
    chk("illegal sticky", obs[1], expv(4'd15, 6'h00, 1'b1, 1'b0));
    @(posedge clk); #1;
    do_reset(1);
    run(1, 6'h00, 6'h22, 3, 0, cyc, irw_n);
    chk("d1 sub cycles", 24'(cyc), 24'd4);
    run(1, 6'h23, 6'h00, 2, 2, cyc, irw_n);
    chk("d1 lw cycles", 24'(cyc), 24'd5);

    // Instance 2: non-trapping, LW/SW disabled.
    do_reset(2);
    run(2, 6'h23, 6'h00, 0, 0, cyc, irw_n);
    chk("d2 lw nop cycles", 24'(cyc), 24'd2);
    run(2, 6'h3F, 6'h00, 0, 0, cyc, irw_n);
    run(2, 6'h00, 6'h21, 0, 0, cyc, irw_n);
    run(2, 6'h05, 6'h00, 0, 0, cyc, irw_n);
    chk("d2 bne cycles", 24'(cyc), 24'd3);
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run(2, op, fn, $urandom_range(0, 2), $urandom_range(0, 2), cyc, irw_n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Next-generation Moore control FSM for the multicycle MIPS core. It sits between the instruction register (opcode/funct) and the datapath muxes, register file, ALU and unified memory.
- Extends the current controller in four ways:
  - LW/SW, BNE and ANDI support.
  - In-FSM R-type funct decode (SUB/AND/OR/SLT in addition to ADD).
  - Optional memory wait-state handshake.
  - Configurable illegal-instruction trapping.

Parameters:
MEM_WAIT, 0, 1: FETCH/MEMRD/MEMWR hold until mem_ready=1; 0: mem_ready ignored, treated as 1
EN_LWSW, 1, 1: opcodes 0x23/0x2B decoded; 0: treated as illegal
EN_BNE, 1, 1: opcode 0x05 decoded; 0: treated as illegal
TRAP_ILLEGAL, 1, 1: illegal instruction enters ILLEGAL (sticky until reset); 0: returns to FETCH (NOP)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
opcode  in  6  IR[31:26], stable from DECODE onward
funct  in  6  IR[5:0]
mem_ready  in  1  memory access completes this cycle
pc_write  out  1  unconditional PC load
branch  out  1  PC load if ALU zero=1
branch_ne  out  1  PC load if ALU zero=0
iord  out  1  memory address select: 0=PC, 1=ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
reg_dst  out  1  write register: 0=rt, 1=rd
mem_to_reg  out  1  write data: 0=ALUOut, 1=MDR
reg_write  out  1  register file write
alu_src_a  out  1  ALU A: 0=PC, 1=rs
alu_src_b  out  2  ALU B: 00=rt, 01=4, 10=imm, 11=imm<<2
alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
pc_src  out  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
imm_zext  out  1  immediate extension: 1=zero-extend, 0=sign-extend
illegal  out  1  high while in ILLEGAL
retire  out  1  one-cycle pulse in the final state of each instruction
state  out  4  current state encoding (debug)

Behaviour:
- Reset and state register:
  - Synchronous: rst=1 at a rising edge sets state=FETCH.
  - While rst=1, all outputs are forced to 0 except state.
  - Reset mid-instruction abandons it; no partial writes are issued after that edge.
- States (encoding):
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, ALUWB=7
  - BEQ=8, ADDIEX=9, IMMWB=10, JUMP=11, ORIEX=12, ANDIEX=13, BNE=14, ILLEGAL=15
- Output decoding:
  - Outputs are combinational from state only, except mem_ready gating and the funct-derived alu_control in RTEX.
  - Unlisted outputs are 0.
- Per-state outputs:
  - FETCH: alu_src_b=01, alu_control=010, ir_write=pc_write=mem_ready (effective). Holds while mem_ready=0, else goes to DECODE.
  - DECODE: alu_src_b=11, alu_control=010. Next state by opcode:
    - 0x00 with funct in {20,22,24,25,2A} -> RTEX
    - 0x23/0x2B -> MEMADR
    - 0x04 -> BEQ
    - 0x05 -> BNE
    - 0x08/0x09 -> ADDIEX
    - 0x0C -> ANDIEX
    - 0x0D -> ORIEX
    - 0x02 -> JUMP
    - anything else (including disabled opcodes) -> ILLEGAL if TRAP_ILLEGAL, else FETCH with retire=1.
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_control=010. Goes to MEMRD if opcode=0x23, else MEMWR.
  - MEMRD: iord=1. Holds until mem_ready, then goes to MEMWB.
  - MEMWB: mem_to_reg=1, reg_write=1, retire=1. Goes to FETCH.
  - MEMWR: iord=1, mem_write=1 held until mem_ready, retire=mem_ready. Goes to FETCH on ready.
  - RTEX: alu_src_a=1, alu_src_b=00, alu_control from funct (20->010, 22->110, 24->000, 25->001, 2A->111). Goes to ALUWB.
  - ALUWB: reg_dst=1, reg_write=1, retire=1. Goes to FETCH.
  - ADDIEX / ANDIEX / ORIEX: alu_src_a=1, alu_src_b=10, alu_control=010 / 000 / 001 respectively. imm_zext=1 for ANDIEX/ORIEX only. All go to IMMWB.
  - IMMWB: reg_dst=0, reg_write=1, retire=1. Goes to FETCH.
  - BEQ / BNE: alu_src_a=1, alu_src_b=00, alu_control=110, pc_src=01, branch=1 (BEQ) or branch_ne=1 (BNE), retire=1. Go to FETCH.
  - JUMP: pc_src=10, pc_write=1, retire=1. Goes to FETCH.
  - ILLEGAL: illegal=1, no writes. Stays in ILLEGAL until rst.
- Invariants:
  - At most one of reg_write/mem_write/pc_write is 1 in any cycle.
  - mem_write is never 1 outside MEMWR.
- Latency with MEM_WAIT=0, in cycles:
  - LW=5, SW=4, R-type/immediate ALU=4, BEQ/BNE/J=3.
  - Each mem_ready=0 cycle adds one cycle.

Test Plan:
- Reset then ADD (op 00, funct 20), mem_ready=1 -> states 0,1,6,7,0. alu_control=010 in RTEX; reg_dst=1, reg_write=1, retire=1 in ALUWB.
- MEM_WAIT=1, LW (0x23), mem_ready low for 2 cycles in FETCH and 3 in MEMRD -> ir_write pulses once, on the ready cycle. iord=1 held through MEMRD. mem_to_reg=1, reg_write=1 exactly once. Total 10 cycles.
- SW (0x2B) -> MEMWR with mem_write=1 and iord=1. No reg_write during the instruction. Returns to FETCH.
- BNE (0x05) with EN_BNE=1 -> branch_ne=1, pc_src=01, alu_control=110. With EN_BNE=0 and TRAP_ILLEGAL=1 -> state=15, illegal=1 until rst.
- ORI (0x0D) and ANDI (0x0C) -> imm_zext=1 and alu_control 001/000 in EX. ADDI -> imm_zext=0. IMMWB reg_dst=0.
- rst asserted in MEMWR with mem_ready=0 -> the next edge gives state=0, all outputs 0 while rst=1. Then a normal fetch runs.
